alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Decode/operand stage directly upstream of the 32-bit ALU. Holds the 32-entry integer register file.
//  Reads rs1/rs2 and selects src_b between rs2 data and the immediate. Registers src_a, src_b, alu_control,
//  rd and reg_write into a single-entry valid/ready pipeline register that drives the ALU inputs.
//  The writeback write port comes back from the downstream stage.
// PARAMETERS
//  XLEN        32  data width of registers, immediate, src_a/src_b
//  REG_ADDR_W  5   register index width; file depth = 2**REG_ADDR_W
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           synchronous, active-low reset
//  in_valid     in   1           decoded instruction fields valid
//  in_ready     out  1           stage can accept this cycle
//  rs1, rs2     in   REG_ADDR_W  source register indices
//  rd_in        in   REG_ADDR_W  destination index
//  imm          in   XLEN        sign-extended immediate
//  alu_src      in   1           1: src_b=imm, 0: src_b=RF[rs2]
//  alu_ctrl_in  in   3           ALU op: 000 add,001 sub,010 and,011 or,100 sll,101 slt
//  reg_wr_in    in   1           instruction writes rd
//  flush        in   1           discard held and incoming instruction
//  wb_we        in   1           writeback enable
//  wb_rd        in   REG_ADDR_W  writeback index
//  wb_data      in   XLEN        writeback data
//  out_valid    out  1           ALU operands valid
//  out_ready    in   1           downstream consumes this cycle
//  src_a        out  XLEN        ALU operand A
//  src_b        out  XLEN        ALU operand B
//  alu_control  out  3           ALU op select
//  rd_out       out  REG_ADDR_W  destination index
//  reg_write    out  1           write-enable forwarded to writeback
//  op_err       out  1           alu_control is 110/111 (unsupported)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all RF entries=0; out_valid=0, src_a=src_b=0, alu_control=000,
//    rd_out=0, reg_write=0, op_err=0. in_ready=0 while rst_n=0.
//  - RF: x0 always reads 0; writes to index 0 are ignored. Write commits at posedge when wb_we=1.
//  - in_ready = rst_n & ~flush & (~out_valid | out_ready). Accept = in_valid & in_ready.
//  - Latency: accept at edge N -> out_valid=1, operands visible after edge N (1 cycle).
//  - On accept: src_a<=RF[rs1]; src_b<=alu_src?imm:RF[rs2]; other fields latched.
//    op_err<=(alu_ctrl_in[2:1]==2'b11); the code is still passed through unchanged.
//  - Sll: imm passed whole; the ALU uses src_b[4:0].
//  - Hold: out_valid=1 & out_ready=0 -> every output stable. A held operand is NOT refreshed by later writebacks.
//  - Drain: out_ready=1 & no accept -> out_valid<=0; data outputs keep their last values.
//  - Back-to-back: out_ready=1 & accept on the same edge -> new instruction replaces old, out_valid stays 1.
//  - flush=1: out_valid<=0, reg_write<=0. No accept that cycle. The RF write still commits.
//    Reset has priority over flush.
//  - Reset mid-hold: the held instruction is lost; out_valid=0 next cycle.
// CONFIGURATION
//  RF_BYPASS_EN defined: a read index equal to wb_rd (nonzero) with wb_we=1 on the accept edge returns
//    wb_data (write-first).
//  Undefined: the same-edge read returns the old RF value; the new value is visible from the next accept.
// TESTING
//  1 Reset: rst_n=0 two cycles -> out_valid=0, src_a=src_b=0, in_ready=0; then read x5 -> 0.
//  2 wb x3=0x0000_0007, x4=0x0000_0002; accept rs1=3,rs2=4,alu_src=0,ctrl=001
//    -> src_a=7, src_b=2, alu_control=001, out_valid=1 one cycle later.
//  3 wb x0=0xFFFF_FFFF, then rs1=0,alu_src=1,imm=0x0000_0003,ctrl=100 -> src_a=0, src_b=3.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen.
//    Then out_ready=1 -> next instruction on the following edge, out_valid stays 1.
//  5 wb_we=1,wb_rd=6,wb_data=0xA5A5_A5A5 on the same edge as accept rs1=6
//    -> src_a=0xA5A5_A5A5 with RF_BYPASS_EN, old value without it.
//  6 flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, reg_write=0;
//    ctrl=111 accepted later -> op_err=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Decode/operand stage feeding the 32-bit ALU. Holds the integer register
//   file (x0 hard-wired to zero), reads rs1/rs2, selects src_b between rs2
//   data and the immediate, and registers the ALU operands plus control
//   fields into a single-entry valid/ready pipeline register.
//
// Configuration macro:
//   RF_BYPASS_EN  when defined, a read of the register being written back on
//                 the same edge returns wb_data (write-first). When undefined
//                 the old register value is returned.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   rs1, rs2, rd_in       register indices
//   imm, alu_src          immediate and src_b select (1: imm, 0: RF[rs2])
//   alu_ctrl_in, reg_wr_in ALU op code and rd write-enable
//   flush                 discard held and incoming instruction
//   wb_we, wb_rd, wb_data register file write port from writeback
//   out_valid / out_ready downstream handshake
//   src_a, src_b, alu_control, rd_out, reg_write  registered ALU inputs
//   op_err                alu_control is an unsupported code (110/111)
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       imm,
  input  logic                  alu_src,
  input  logic [2:0]            alu_ctrl_in,
  input  logic                  reg_wr_in,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       src_a,
  output logic [XLEN-1:0]       src_b,
  output logic [2:0]            alu_control,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write,
  output logic                  op_err
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

  logic [XLEN-1:0] rf [DEPTH];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            accept;

  assign in_ready = rst_n & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Read ports: x0 always reads zero regardless of bypass.
  always_comb begin
    rs1_data = rf[rs1];
    rs2_data = rf[rs2];
`ifdef RF_BYPASS_EN
    if (wb_we && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_we && (wb_rd == rs2)) rs2_data = wb_data;
`endif
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

  // Register file; writes to x0 are dropped so entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Pipeline register. Flush only clears valid and reg_write; operand data
  // keeps its last value, as it does on a plain drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      src_a       <= '0;
      src_b       <= '0;
      alu_control <= '0;
      rd_out      <= '0;
      reg_write   <= 1'b0;
      op_err      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      src_a       <= rs1_data;
      src_b       <= alu_src ? imm : rs2_data;
      alu_control <= alu_ctrl_in;
      rd_out      <= rd_in;
      reg_write   <= reg_wr_in;
      op_err      <= (alu_ctrl_in[2:1] == 2'b11);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1, rs2, rd_in;
  logic [31:0] imm;
  logic        alu_src;
  logic [2:0]  alu_ctrl_in;
  logic        reg_wr_in;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src_a, src_b;
  logic [2:0]  alu_control;
  logic [4:0]  rd_out;
  logic        reg_write;
  logic        op_err;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .imm(imm), .alu_src(alu_src),
    .alu_ctrl_in(alu_ctrl_in), .reg_wr_in(reg_wr_in), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .src_a(src_a), .src_b(src_b),
    .alu_control(alu_control), .rd_out(rd_out), .reg_write(reg_write), .op_err(op_err)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        last = '0;
  logic [31:0] mrf [32];
  logic        mdl_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_entry(input exp_t e);
    chk("src_a", src_a, e.a);
    chk("src_b", src_b, e.b);
    chk("alu_control", {29'd0, alu_control}, {29'd0, e.ctrl});
    chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
    chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
    chk("op_err", {31'd0, op_err}, {31'd0, e.err});
  endtask

  // Architectural register read as seen by an instruction accepted this edge.
  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wb_we && wb_rd == idx) return wb_data;
`endif
    return mrf[idx];
  endfunction

  // One cycle: inputs already driven; predict handshake, push expectation,
  // advance the clock and the reference state.
  task automatic tick();
    logic exp_rdy, acc;
    exp_t e;
    #1;
    exp_rdy = rst_n & ~flush & (~mdl_valid | out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mdl_valid});
    acc = in_valid & exp_rdy;
    if (acc) begin
      e.a    = mread(rs1);
      e.b    = alu_src ? imm : mread(rs2);
      e.ctrl = alu_ctrl_in;
      e.rd   = rd_in;
      e.rw   = reg_wr_in;
      e.err  = (alu_ctrl_in >= 3'd6);
      q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    end else if (wb_we && wb_rd != 5'd0) begin
      mrf[wb_rd] = wb_data;
    end
    if (!rst_n || flush) mdl_valid = 1'b0;
    else if (acc)        mdl_valid = 1'b1;
    else if (out_ready)  mdl_valid = 1'b0;
    #1;
  endtask

  // Monitor: mid-cycle, compare the presented output to the queue head (or to
  // the retained values when idle), then retire per the upcoming edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else cmp_entry(q[0]);
      end else begin
        cmp_entry(last);
      end
      if (!rst_n) begin
        if (out_valid === 1'b1 && q.size() > 0) void'(q.pop_front());
        last = '0;
      end else if (flush) begin
        if (out_valid === 1'b1 && q.size() > 0) last = q.pop_front();
        last.rw = 1'b0;
      end else if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
        last = q.pop_front();
      end
    end
  end

  task automatic instr(input logic [4:0] a, input logic [4:0] b, input logic s,
                       input logic [31:0] im, input logic [2:0] c, input logic [4:0] d,
                       input logic w);
    in_valid = 1'b1; rs1 = a; rs2 = b; alu_src = s; imm = im;
    alu_ctrl_in = c; rd_in = d; reg_wr_in = w;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd_in = '0; imm = '0;
    alu_src = 1'b0; alu_ctrl_in = '0; reg_wr_in = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    @(posedge clk);
    #1;
    tick();                      // second reset cycle: in_ready=0, out_valid=0
    rst_n = 1'b1;

    // 1: read x5 after reset
    instr(5'd5, 5'd5, 1'b0, 32'd0, 3'd0, 5'd1, 1'b1); tick();
    in_valid = 1'b0; tick();

    // 2: x3=7, x4=2, sub
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h7; tick();
    wb_rd = 5'd4; wb_data = 32'h2; tick();
    wb_we = 1'b0;
    instr(5'd3, 5'd4, 1'b0, 32'd0, 3'b001, 5'd8, 1'b1); tick();
    in_valid = 1'b0; tick();

    // 3: write to x0 ignored, sll with immediate
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; tick();
    wb_we = 1'b0;
    instr(5'd0, 5'd4, 1'b1, 32'h3, 3'b100, 5'd9, 1'b1); tick();
    in_valid = 1'b0; tick();

    // 4: hold for 3 cycles while a writeback changes x3, then back-to-back
    out_ready = 1'b0;
    instr(5'd3, 5'd4, 1'b0, 32'd0, 3'b010, 5'd10, 1'b1); tick();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
    instr(5'd4, 5'd3, 1'b0, 32'd0, 3'b011, 5'd11, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    wb_we = 1'b0; out_ready = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();

    // 5: same-edge writeback and read of x6
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'hA5A5_A5A5;
    instr(5'd6, 5'd6, 1'b0, 32'd0, 3'b000, 5'd12, 1'b1); tick();
    wb_we = 1'b0; in_valid = 1'b0; tick();

    // 6: flush while holding with in_valid=1, then unsupported op
    out_ready = 1'b0;
    instr(5'd6, 5'd3, 1'b1, 32'hFFFF_FFF0, 3'b101, 5'd13, 1'b1); tick();
    flush = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE_F00D; tick();
    flush = 1'b0; wb_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    instr(5'd7, 5'd0, 1'b0, 32'd0, 3'b111, 5'd14, 1'b1); tick();
    in_valid = 1'b0; tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      rs1       = 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      rd_in     = 5'($urandom_range(0, 31));
      imm       = $urandom;
      alu_src   = 1'($urandom_range(0, 1));
      alu_ctrl_in = 3'($urandom_range(0, 7));
      reg_wr_in = 1'($urandom_range(0, 1));
      wb_we     = ($urandom_range(0, 1) != 0);
      wb_rd     = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      tick();
    end

    // Drain
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
